// File: rtl/spi_txn_arbiter.sv
// Two-requester arbiter in front of a single SPI shift engine: picks a winner, frames the
// transfer with chip-select setup/hold, times out hung transfers and routes the response back.
module spi_txn_arbiter #(
    parameter int DATA_W       = 16,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              ACLK,
    input  logic              ARESET,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_data,
    input  logic [1:0]        r0_cs,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_data,
    output logic              r0_rsp_err,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_data,
    input  logic [1:0]        r1_cs,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_data,
    output logic              r1_rsp_err,

    output logic              eng_start,
    output logic              eng_abort,
    output logic [DATA_W-1:0] eng_tx,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_rx,

    output logic [3:0]        cs_n,
    output logic              busy
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [7:0]      SETUP_LAST = 8'(CS_SETUP_CYC - 1);
    localparam logic [7:0]      HOLD_LAST  = 8'(CS_HOLD_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [TO_W-1:0]          to_q, to_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic [3:0]               cs_n_q, cs_n_d;
    logic                     eng_start_q, eng_start_d;
    logic                     eng_abort_q, eng_abort_d;
    logic                     busy_q, busy_d;
    logic [1:0]               rsp_valid_q, rsp_valid_d;
    logic [1:0]               rsp_err_q, rsp_err_d;
    logic [1:0][DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic idle;
    logic win1;
    logic [1:0] sel_cs;

    // On a tie the requester that did not win last time goes first.
    assign idle     = (state_q == S_IDLE);
    assign win1     = r1_valid && (!r0_valid || !last_q);
    assign r0_ready = idle && r0_valid && !win1;
    assign r1_ready = idle && win1;
    assign sel_cs   = win1 ? r1_cs : r0_cs;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        owner_d     = owner_q;
        last_d      = last_q;
        data_d      = data_q;
        cs_n_d      = cs_n_q;
        eng_start_d = 1'b0;
        eng_abort_d = 1'b0;
        rsp_valid_d = 2'b00;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (r0_ready || r1_ready) begin
                    owner_d         = win1;
                    last_d          = win1;
                    data_d          = win1 ? r1_data : r0_data;
                    cs_n_d          = 4'hF;
                    cs_n_d[sel_cs]  = 1'b0;
                    cnt_d           = 8'd0;
                    state_d         = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d     = S_START;
                    eng_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // A done arriving in the final allowed cycle still wins over the timeout.
                if (eng_done) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d[owner_q]   = 1'b0;
                    rsp_data_d[owner_q]  = eng_rx;
                    cnt_d                = 8'd0;
                    state_d              = S_HOLD;
                end else if (to_q == TO_LAST) begin
                    eng_abort_d          = 1'b1;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d[owner_q]   = 1'b1;
                    rsp_data_d[owner_q]  = '0;
                    cnt_d                = 8'd0;
                    state_d              = S_HOLD;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cs_n_d  = 4'hF;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                cs_n_d  = 4'hF;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            to_q        <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            data_q      <= '0;
            cs_n_q      <= 4'hF;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            data_q      <= data_d;
            cs_n_q      <= cs_n_d;
            eng_start_q <= eng_start_d;
            eng_abort_q <= eng_abort_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign eng_start    = eng_start_q;
    assign eng_abort    = eng_abort_q;
    assign eng_tx       = data_q;
    assign cs_n         = cs_n_q;
    assign busy         = busy_q;
    assign r0_rsp_valid = rsp_valid_q[0];
    assign r0_rsp_err   = rsp_err_q[0];
    assign r0_rsp_data  = rsp_data_q[0];
    assign r1_rsp_valid = rsp_valid_q[1];
    assign r1_rsp_err   = rsp_err_q[1];
    assign r1_rsp_data  = rsp_data_q[1];

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: a transaction-timeline model checks the default instance every
// cycle; a second instance with an 8-cycle timeout is checked against literal timelines.
module tb_spi_txn_arbiter;

    localparam int SU = 4;
    localparam int HD = 4;
    localparam int TO = 1024;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;

    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [15:0] r0_data = '0, r1_data = '0;
    logic [1:0]  r0_cs = '0, r1_cs = '0;
    logic        r0_ready, r1_ready;
    logic        r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
    logic [15:0] r0_rsp_data, r1_rsp_data;
    logic        eng_start, eng_abort, eng_done;
    logic [15:0] eng_tx;
    logic [15:0] eng_rx = '0;
    logic [3:0]  cs_n;
    logic        busy;
    logic        eng_auto = 1'b0, eng_spur = 1'b0;
    int          eng_lat = 0;
    assign eng_done = eng_auto | eng_spur;

    logic        t_r0_valid = 1'b0, t_r1_valid = 1'b0;
    logic [15:0] t_r0_data = '0, t_r1_data = '0;
    logic [1:0]  t_r0_cs = '0, t_r1_cs = '0;
    logic        t_r0_ready, t_r1_ready;
    logic        t_r0_rsp_valid, t_r1_rsp_valid, t_r0_rsp_err, t_r1_rsp_err;
    logic [15:0] t_r0_rsp_data, t_r1_rsp_data;
    logic        t_start, t_abort;
    logic        t_done = 1'b0;
    logic [15:0] t_tx;
    logic [15:0] t_rx = '0;
    logic [3:0]  t_cs_n;
    logic        t_busy;

    spi_txn_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_cs(r0_cs),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_cs(r1_cs),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_tx(eng_tx),
        .eng_done(eng_done), .eng_rx(eng_rx), .cs_n(cs_n), .busy(busy)
    );

    spi_txn_arbiter #(.TIMEOUT_CYC(8)) dut8 (
        .ACLK(ACLK), .ARESET(ARESET),
        .r0_valid(t_r0_valid), .r0_ready(t_r0_ready), .r0_data(t_r0_data), .r0_cs(t_r0_cs),
        .r0_rsp_valid(t_r0_rsp_valid), .r0_rsp_data(t_r0_rsp_data), .r0_rsp_err(t_r0_rsp_err),
        .r1_valid(t_r1_valid), .r1_ready(t_r1_ready), .r1_data(t_r1_data), .r1_cs(t_r1_cs),
        .r1_rsp_valid(t_r1_rsp_valid), .r1_rsp_data(t_r1_rsp_data), .r1_rsp_err(t_r1_rsp_err),
        .eng_start(t_start), .eng_abort(t_abort), .eng_tx(t_tx),
        .eng_done(t_done), .eng_rx(t_rx), .cs_n(t_cs_n), .busy(t_busy)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // Shift engine stand-in: done eng_lat cycles after the start cycle (0 = never).
    int ecnt = 0;
    initial forever begin
        @(negedge ACLK);
        eng_auto = 1'b0;
        if (ARESET) ecnt = 0;
        else if (eng_start) ecnt = eng_lat;
        else if (ecnt > 0) begin
            ecnt--;
            if (ecnt == 0) eng_auto = 1'b1;
        end
    end

    // Model: a transaction is a timeline counted from its handshake. k is cycles since the
    // handshake; the response cycle rk becomes known when done arrives or the timeout expires.
    bit          m_on = 0, m_busy = 0, m_own = 0, m_last = 1, m_err = 0;
    int          m_k = 0, m_rk = 0;
    logic [1:0]  m_idx = '0;
    logic [15:0] m_tx = '0;
    logic [15:0] m_rd [2];
    bit          m_re [2];

    initial forever begin
        @(posedge ACLK);
        if (ARESET) begin
            m_on = 1; m_busy = 0; m_last = 1; m_err = 0; m_rk = 0;
            m_rd[0] = '0; m_rd[1] = '0; m_re[0] = 0; m_re[1] = 0;
        end else if (m_on) begin
            if (!m_busy) begin
                if (r0_valid || r1_valid) begin
                    m_own  = (r0_valid && r1_valid) ? !m_last : r1_valid;
                    m_last = m_own;
                    m_idx  = m_own ? r1_cs : r0_cs;
                    m_tx   = m_own ? r1_data : r0_data;
                    m_busy = 1; m_k = 1; m_rk = 0; m_err = 0;
                end
            end else begin
                if (m_rk == 0 && m_k >= SU + 2) begin
                    if (eng_done) begin
                        m_rk = m_k + 1; m_err = 0;
                        m_rd[m_own] = eng_rx; m_re[m_own] = 0;
                    end else if (m_k - (SU + 1) == TO) begin
                        m_rk = m_k + 1; m_err = 1;
                        m_rd[m_own] = '0; m_re[m_own] = 1;
                    end
                end
                if (m_rk != 0 && m_k == m_rk + HD) m_busy = 0;
                else m_k++;
            end
        end
    end

    initial forever begin
        logic [3:0] e_cs;
        bit e_start, e_rsp0, e_rsp1, e_rdy0, e_rdy1;
        @(negedge ACLK);
        if (m_on) begin
            e_cs = 4'hF;
            if (m_busy && !(m_rk != 0 && m_k >= m_rk + HD)) e_cs[m_idx] = 1'b0;
            e_start = m_busy && (m_k == SU + 1);
            e_rsp0  = m_busy && (m_rk == m_k) && !m_own;
            e_rsp1  = m_busy && (m_rk == m_k) && m_own;
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_cs_n", 32'(cs_n), 32'(e_cs));
            chk("m_eng_start", 32'(eng_start), 32'(e_start));
            if (e_start) chk("m_eng_tx", 32'(eng_tx), 32'(m_tx));
            chk("m_eng_abort", 32'(eng_abort), 32'(m_busy && m_rk == m_k && m_err));
            chk("m_r0_rsp_valid", 32'(r0_rsp_valid), 32'(e_rsp0));
            chk("m_r1_rsp_valid", 32'(r1_rsp_valid), 32'(e_rsp1));
            chk("m_r0_rsp_data", 32'(r0_rsp_data), 32'(m_rd[0]));
            chk("m_r1_rsp_data", 32'(r1_rsp_data), 32'(m_rd[1]));
            chk("m_r0_rsp_err", 32'(r0_rsp_err), 32'(m_re[0]));
            chk("m_r1_rsp_err", 32'(r1_rsp_err), 32'(m_re[1]));
            if (!ARESET) begin
                e_rdy0 = !m_busy && r0_valid && (!r1_valid || m_last);
                e_rdy1 = !m_busy && r1_valid && (!r0_valid || !m_last);
                chk("m_r0_ready", 32'(r0_ready), 32'(e_rdy0));
                chk("m_r1_ready", 32'(r1_ready), 32'(e_rdy1));
            end
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            if (!busy) break;
        end
        chk(name, 32'(busy), 0);
        step();
    endtask

    // Timeout instance: r1 on cs 1; off = response cycle relative to the handshake.
    task automatic run_t8(input int lat, input logic [15:0] rx, input int off,
                          input bit err, input logic [15:0] dat);
        t_rx = rx; t_r1_data = 16'h3C3C; t_r1_cs = 2'd1; t_r1_valid = 1'b1;
        @(negedge ACLK);
        chk("t8_ready", 32'(t_r1_ready), 1);
        step();
        t_r1_valid = 1'b0;
        for (int k = 1; k <= off + 5; k++) begin
            t_done = (lat != 0 && k == 5 + lat);
            @(negedge ACLK);
            chk("t8_rsp_valid", 32'(t_r1_rsp_valid), 32'(k == off));
            chk("t8_abort", 32'(t_abort), 32'(err && k == off));
            chk("t8_r0_rsp_valid", 32'(t_r0_rsp_valid), 0);
            chk("t8_r0_rsp_err", 32'(t_r0_rsp_err), 0);
            chk("t8_cs_n", 32'(t_cs_n), (k < off + 4) ? 32'hD : 32'hF);
            if (k == 5) begin
                chk("t8_start", 32'(t_start), 1);
                chk("t8_tx", 32'(t_tx), 32'h3C3C);
            end
            if (k >= off) begin
                chk("t8_rsp_data", 32'(t_r1_rsp_data), 32'(dat));
                chk("t8_rsp_err", 32'(t_r1_rsp_err), 32'(err));
            end
            if (k == off + 5) chk("t8_busy_end", 32'(t_busy), 0);
            step();
        end
        t_done = 1'b0;
    endtask

    int gq[$];
    int gc[$];
    int busy_rdy;

    initial begin
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_data", 32'(r0_rsp_data), 0);
        chk("rst_t8_cs_n", 32'(t_cs_n), 32'hF);
        chk("rst_t8_busy", 32'(t_busy), 0);
        step();

        // r0 alone, cs 2, engine done 16 cycles after start.
        eng_lat = 16; eng_rx = 16'h1234;
        r0_data = 16'hA5C3; r0_cs = 2'd2; r0_valid = 1'b1;
        @(negedge ACLK);
        chk("t1_ready", 32'(r0_ready), 1);
        step();
        r0_valid = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge ACLK);
            if (k == 1)  chk("t1_cs_n_setup", 32'(cs_n), 32'hB);
            if (k == 4)  chk("t1_no_start", 32'(eng_start), 0);
            if (k == 5)  chk("t1_start", 32'(eng_start), 1);
            if (k == 5)  chk("t1_tx", 32'(eng_tx), 32'hA5C3);
            if (k == 21) chk("t1_rsp_early", 32'(r0_rsp_valid), 0);
            if (k == 22) chk("t1_rsp_valid", 32'(r0_rsp_valid), 1);
            if (k == 22) chk("t1_rsp_data", 32'(r0_rsp_data), 32'h1234);
            if (k == 25) chk("t1_cs_n_hold", 32'(cs_n), 32'hB);
            if (k == 26) chk("t1_cs_n_gap", 32'(cs_n), 32'hF);
            if (k == 26) chk("t1_busy_gap", 32'(busy), 1);
            if (k == 27) chk("t1_busy_idle", 32'(busy), 0);
            step();
        end

        // Reset during SHIFT, then both requesters continuously valid.
        eng_lat = 0;
        r0_data = 16'h1111; r0_cs = 2'd0; r0_valid = 1'b1;
        @(negedge ACLK);
        chk("t3_ready", 32'(r0_ready), 1);
        step();
        r0_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge ACLK);
            if (k == 8) chk("t3_cs_n_shift", 32'(cs_n), 32'hE);
            if (k < 8) step();
        end
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        eng_lat = 2; eng_rx = 16'hC0DE;
        r0_data = 16'h00A0; r0_cs = 2'd1; r1_data = 16'h00B1; r1_cs = 2'd3;
        r0_valid = 1'b1; r1_valid = 1'b1;
        @(negedge ACLK);
        chk("t3_cs_n_after", 32'(cs_n), 32'hF);
        chk("t3_busy_after", 32'(busy), 0);
        chk("t3_no_rsp0", 32'(r0_rsp_valid), 0);
        chk("t3_no_rsp_data", 32'(r0_rsp_data), 0);
        chk("t3_r0_first", 32'(r0_ready), 1);
        gq.delete(); gc.delete(); busy_rdy = 0;
        for (int i = 0; i < 46; i++) begin
            if (i > 0) @(negedge ACLK);
            if (r0_ready) begin gq.push_back(0); gc.push_back(cyc); end
            if (r1_ready) begin gq.push_back(1); gc.push_back(cyc); end
            if (busy && (r0_ready || r1_ready)) busy_rdy++;
        end
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        chk("t2_grant_count", 32'(gq.size()), 4);
        for (int i = 0; i < 4; i++)
            chk("t2_grant_order", (i < gq.size()) ? 32'(gq[i]) : 32'd9, 32'(i % 2));
        chk("t2_spacing", (gc.size() >= 2) ? 32'(gc[1] - gc[0]) : 32'd0, 32'd13);
        chk("t2_ready_while_busy", 32'(busy_rdy), 0);
        wait_idle("t2_idle");

        // Spurious done in IDLE and in SETUP.
        eng_spur = 1'b1;
        step();
        eng_spur = 1'b0;
        eng_lat = 5; eng_rx = 16'h5A5A;
        r1_data = 16'h0F0F; r1_cs = 2'd3; r1_valid = 1'b1;
        @(negedge ACLK);
        chk("t5_ready", 32'(r1_ready), 1);
        step();
        r1_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            eng_spur = (k == 2);
            @(negedge ACLK);
            if (k == 1)  chk("t5_cs_n", 32'(cs_n), 32'h7);
            if (k == 3)  chk("t5_no_rsp_setup", 32'(r1_rsp_valid), 0);
            if (k == 10) chk("t5_no_rsp_early", 32'(r1_rsp_valid), 0);
            if (k == 11) chk("t5_rsp_valid", 32'(r1_rsp_valid), 1);
            if (k == 11) chk("t5_rsp_data", 32'(r1_rsp_data), 32'h5A5A);
            if (k == 15) chk("t5_cs_n_gap", 32'(cs_n), 32'hF);
            if (k == 16) chk("t5_busy_idle", 32'(busy), 0);
            step();
        end
        eng_spur = 1'b0;

        // 8-cycle timeout instance: early done, done on the last SHIFT cycle, no done.
        run_t8(3, 16'hBEEF, 9, 1'b0, 16'hBEEF);
        run_t8(8, 16'h7777, 14, 1'b0, 16'h7777);
        run_t8(0, 16'h9999, 14, 1'b1, 16'h0000);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 SHALL take parameter DATA_W, default 16, meaning SPI word width in bits.
REQ-002 SHALL take parameter CS_SETUP_CYC, default 4, meaning the number of cycles chip-select is asserted before the engine starts (valid range 1..255).
REQ-003 SHALL take parameter CS_HOLD_CYC, default 4, meaning the number of cycles chip-select stays asserted after the response (valid range 1..255).
REQ-004 SHALL take parameter TIMEOUT_CYC, default 1024, meaning the maximum number of SHIFT cycles before a transaction is aborted.
REQ-005 SHALL have port ACLK, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-006 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports r0_valid/r1_valid, input, 1 bit each: requester has a transaction pending.
REQ-008 SHALL have ports r0_ready/r1_ready, output, 1 bit each: requester transaction accepted this cycle.
REQ-009 SHALL have ports r0_data/r1_data, input, DATA_W bits each: word to shift out.
REQ-010 SHALL have ports r0_cs/r1_cs, input, 2 bits each: target chip-select index.
REQ-011 SHALL have ports r0_rsp_valid/r1_rsp_valid, output, 1 bit each: one-cycle response strobe.
REQ-012 SHALL have ports r0_rsp_data/r1_rsp_data, output, DATA_W bits each: received word.
REQ-013 SHALL have ports r0_rsp_err/r1_rsp_err, output, 1 bit each: the response was a timeout.
REQ-014 SHALL have ports eng_start (output, 1 bit), eng_abort (output, 1 bit) and eng_tx (output, DATA_W bits) driving the shift engine.
REQ-015 SHALL have ports eng_done (input, 1 bit) and eng_rx (input, DATA_W bits) from the shift engine.
REQ-016 SHALL have ports cs_n (output, 4 bits, active-low selects) and busy (output, 1 bit, state != IDLE).

Function
REQ-017 SHALL implement the states IDLE, SETUP, START, SHIFT, HOLD and GAP, with one transaction in flight at most.
REQ-018 SHALL, in IDLE, select a winner from the valid requesters: if only one is valid it wins; if both are valid, the one not granted last wins; after reset r0 has priority.
REQ-019 SHALL assert only the winner's rN_ready, combinationally, in IDLE; this handshake cycle T captures data, cs index and requester id, and the next state is SETUP.
REQ-020 SHALL drive cs_n[idx] low from T+1 through the last HOLD cycle, with all other cs_n bits high.
REQ-021 SHALL hold SETUP for exactly CS_SETUP_CYC cycles, then spend 1 cycle in START with eng_start=1 and eng_tx=the captured data; eng_start is 0 in all other states.
REQ-022 SHALL wait in SHIFT for eng_done; on eng_done in cycle D, eng_rx is captured, and rsp_valid=1, rsp_err=0 and rsp_data=the captured word are driven to the owning requester only in cycle D+1.
REQ-023 SHALL, if TIMEOUT_CYC SHIFT cycles elapse without eng_done, pulse eng_abort for 1 cycle and give the owner rsp_valid=1, rsp_err=1, rsp_data=0 in the next cycle.
REQ-024 SHALL enter HOLD in the rsp_valid cycle and stay there for CS_HOLD_CYC cycles, then go to GAP for 1 cycle with all cs_n high, then to IDLE.
REQ-025 SHALL ignore eng_done outside SHIFT; eng_done coincident with the timeout expiry counts as success.
REQ-026 SHALL hold rN_rsp_data and rN_rsp_err at their last values between strobes, while rN_rsp_valid is 0 except for the single strobe.
REQ-027 SHALL leave an un-granted requester's valid pending with no drop and no ready; requests arriving during non-IDLE states wait until IDLE.
REQ-028 SHALL give minimum back-to-back transaction spacing, handshake to handshake, of CS_SETUP_CYC+1+(SHIFT cycles)+CS_HOLD_CYC+1+1.

Reset
REQ-029 SHALL, while ARESET=1 at a clock edge, go to IDLE with cs_n=4'hF, all ready/rsp_valid/rsp_err=0, rsp_data=0, eng_start=0, eng_abort=0, busy=0 and last-grant=r1 (so r0 wins first).
REQ-030 SHALL, on reset mid-transaction, produce no response strobe, and cs_n returns to 4'hF in the first post-edge cycle.

Verification
REQ-031 SHALL cover: r0 alone (data 16'hA5C3, cs 2, default parameters) with the engine returning done 16 cycles after start with rx 16'h1234 -> cs_n=4'b1011 from T+1, eng_start at T+5, r0_rsp_valid with 16'h1234 at done+1, cs_n=4'hF after 4 HOLD cycles.
REQ-032 SHALL cover: r0 and r1 valid simultaneously and continuously -> grants r0, r1, r0, r1; no rN_ready while busy.
REQ-033 SHALL cover: engine never asserting done, TIMEOUT_CYC=8 -> eng_abort pulses after 8 SHIFT cycles and r1_rsp_err=1, r1_rsp_data=0 on the owning port only.
REQ-034 SHALL cover: ARESET asserted during SHIFT -> cs_n=4'hF and busy=0 next cycle, no rsp_valid, and the next request is granted to r0.
REQ-035 SHALL cover: a spurious eng_done in IDLE and in SETUP -> ignored; the subsequent transaction completes on the real done.
